// File: rtl/aixh_mxc_upper_hchain_pkg.sv
// rtl/aixh_mxc_upper_hchain_pkg.sv - shared types, constants and helpers for the MXC upper horizontal chain
// Contents:
//   hchain_tid_t                  generic tile-index type (wide enough for any supported NTILE)
//   HCHAIN_DEFAULT_REPEATER_MASK  default hop placement (no repeaters)
//   hchain_fifo_aw()              address width of a per-tile FIFO of a given depth
//   hchain_next_tid()             tile index increment with wrap at ntile
package aixh_mxc_upper_hchain_pkg;

    localparam int HCHAIN_TID_MAX_W = 8;

    typedef logic [HCHAIN_TID_MAX_W-1:0] hchain_tid_t;

    localparam logic [255:0] HCHAIN_DEFAULT_REPEATER_MASK = '0;

    function automatic int hchain_fifo_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic hchain_tid_t hchain_next_tid(input hchain_tid_t tid, input int ntile);
        return (int'(tid) >= ntile - 1) ? '0 : tid + hchain_tid_t'(1);
    endfunction

endpackage

// File: rtl/aixh_mxc_upper_hchain_if.sv
// rtl/aixh_mxc_upper_hchain_if.sv - merged backward result stream between the chain and the left-edge consumer
// Signals:
//   vld  result valid (held until transferred)
//   dat  result data, DWIDTH bits
//   tid  source tile of dat, TIDW bits
//   rdy  consumer ready
// Modports: master (chain side), slave (consumer side)
interface aixh_mxc_upper_hchain_if #(
    parameter int DWIDTH = 64,
    parameter int TIDW   = 3
) ();

    logic              vld;
    logic [DWIDTH-1:0] dat;
    logic [TIDW-1:0]   tid;
    logic              rdy;

    modport master (output vld, output dat, output tid, input rdy);
    modport slave  (input vld, input dat, input tid, output rdy);

endinterface

// File: rtl/aixh_mxc_upper_bwd_fifo.sv
// rtl/aixh_mxc_upper_bwd_fifo.sv - per-tile synchronous result FIFO with overflow pulse
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push, wdat  write request and data (a push into a full FIFO is dropped unless the same edge pops)
//   pop, rdat   read request and head-of-queue data
//   empty       FIFO holds no entries
//   ovf         single-cycle pulse when a push is dropped
module aixh_mxc_upper_bwd_fifo
    import aixh_mxc_upper_hchain_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DWIDTH = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DWIDTH-1:0] wdat,
    input  logic              pop,
    output logic [DWIDTH-1:0] rdat,
    output logic              empty,
    output logic              ovf
);

    localparam int AW = hchain_fifo_aw(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [AW:0]       count;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A slot freed by a same-edge pop is immediately reusable.
    assign do_push = push & (~full | do_pop);
    assign ovf     = push & full & ~do_pop;
    assign rdat    = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdat;
    end

endmodule

// File: rtl/aixh_mxc_upper_hchain.sv
// rtl/aixh_mxc_upper_hchain.sv - MXC upper horizontal command/result chain
// Ports:
//   aixh_core_clk2x, aixh_core_rstn   clock, asynchronous active-low reset
//   i_fwd_vld, i_fwd_cmd              command from ctrl
//   o_tile_cmd_vld, o_tile_cmd        per-tile command, delayed by the repeater hops up to that tile
//   i_tile_bwd_vld, i_tile_bwd_dat    per-tile results (tiles cannot be stalled)
//   bwd                               merged result stream (master side)
//   o_ovf, i_ovf_clr                  sticky per-tile overflow flags and their clear
// Build option: AIXH_MXC_HCHAIN_ORDERED_EN selects strict tile-order draining instead of round-robin.
module aixh_mxc_upper_hchain
    import aixh_mxc_upper_hchain_pkg::*;
#(
    parameter int               NTILE         = 8,
    parameter int               CWIDTH        = 32,
    parameter int               DWIDTH        = 64,
    parameter int               FIFO_DEPTH    = 4,
    parameter logic [NTILE-1:0] REPEATER_MASK = HCHAIN_DEFAULT_REPEATER_MASK[NTILE-1:0]
) (
    input  logic                      aixh_core_clk2x,
    input  logic                      aixh_core_rstn,
    input  logic                      i_fwd_vld,
    input  logic [CWIDTH-1:0]         i_fwd_cmd,
    output logic [NTILE-1:0]          o_tile_cmd_vld,
    output logic [NTILE*CWIDTH-1:0]   o_tile_cmd,
    input  logic [NTILE-1:0]          i_tile_bwd_vld,
    input  logic [NTILE*DWIDTH-1:0]   i_tile_bwd_dat,
    aixh_mxc_upper_hchain_if.master   bwd,
    output logic [NTILE-1:0]          o_ovf,
    input  logic                      i_ovf_clr
);

    localparam int TIDW = $clog2(NTILE);

    // ---------------- forward hop chain ----------------
    logic              tile_vld [NTILE];
    logic [CWIDTH-1:0] tile_cmd [NTILE];

    for (genvar x = 0; x < NTILE; x++) begin : g_fwd
        logic              prev_vld;
        logic [CWIDTH-1:0] prev_cmd;

        if (x == 0) begin : g_src
            assign prev_vld = i_fwd_vld;
            assign prev_cmd = i_fwd_cmd;
        end else begin : g_chain
            assign prev_vld = tile_vld[x-1];
            assign prev_cmd = tile_cmd[x-1];
        end

        if (REPEATER_MASK[x]) begin : g_hop
            logic              hop_vld;
            logic [CWIDTH-1:0] hop_cmd;
            // cmd only follows a valid beat so idle cycles do not toggle the wide bus.
            always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn) begin
                if (!aixh_core_rstn) begin
                    hop_vld <= 1'b0;
                    hop_cmd <= '0;
                end else begin
                    hop_vld <= prev_vld;
                    if (prev_vld) hop_cmd <= prev_cmd;
                end
            end
            assign tile_vld[x] = hop_vld;
            assign tile_cmd[x] = hop_cmd;
        end else begin : g_thru
            assign tile_vld[x] = prev_vld;
            assign tile_cmd[x] = prev_cmd;
        end

        assign o_tile_cmd_vld[x]                = tile_vld[x];
        assign o_tile_cmd[x*CWIDTH +: CWIDTH]   = tile_cmd[x];
    end

    // ---------------- backward FIFOs ----------------
    logic [DWIDTH-1:0] fifo_rdat [NTILE];
    logic [NTILE-1:0]  fifo_empty;
    logic [NTILE-1:0]  fifo_ovf;
    logic [NTILE-1:0]  fifo_pop;
    logic              load_en;
    logic              grant_vld;
    logic [TIDW-1:0]   grant;

    for (genvar x = 0; x < NTILE; x++) begin : g_bwd
        assign fifo_pop[x] = load_en & grant_vld & (grant == TIDW'(x));

        aixh_mxc_upper_bwd_fifo #(
            .DEPTH  (FIFO_DEPTH),
            .DWIDTH (DWIDTH)
        ) u_fifo (
            .clk   (aixh_core_clk2x),
            .rst_n (aixh_core_rstn),
            .push  (i_tile_bwd_vld[x]),
            .wdat  (i_tile_bwd_dat[x*DWIDTH +: DWIDTH]),
            .pop   (fifo_pop[x]),
            .rdat  (fifo_rdat[x]),
            .empty (fifo_empty[x]),
            .ovf   (fifo_ovf[x])
        );
    end

    // ---------------- arbiter and output register ----------------
    logic              out_vld;
    logic [DWIDTH-1:0] out_dat;
    logic [TIDW-1:0]   out_tid;
    logic [TIDW-1:0]   ptr;
    logic [NTILE-1:0]  ovf_q;

    // The output slot refills whenever it is empty or being consumed this edge.
    assign load_en = ~out_vld | bwd.rdy;

`ifdef AIXH_MXC_HCHAIN_ORDERED_EN
    always_comb begin
        grant_vld = ~fifo_empty[ptr];
        grant     = ptr;
    end
`else
    int              rr_idx;
    logic [TIDW-1:0] rr_cand;

    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        rr_idx    = 0;
        rr_cand   = '0;
        for (int i = 0; i < NTILE; i++) begin
            rr_idx = int'(ptr) + i;
            if (rr_idx >= NTILE) rr_idx = rr_idx - NTILE;
            rr_cand = rr_idx[TIDW-1:0];
            if (!grant_vld && !fifo_empty[rr_cand]) begin
                grant_vld = 1'b1;
                grant     = rr_cand;
            end
        end
    end
`endif

    always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn) begin
        if (!aixh_core_rstn) begin
            out_vld <= 1'b0;
            out_dat <= '0;
            out_tid <= '0;
            ptr     <= '0;
        end else if (load_en) begin
            out_vld <= grant_vld;
            if (grant_vld) begin
                out_dat <= fifo_rdat[grant];
                out_tid <= grant;
                ptr     <= TIDW'(hchain_next_tid(hchain_tid_t'(grant), NTILE));
            end
        end
    end

    // A new overflow in the same cycle as a clear must stay visible.
    always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn) begin
        if (!aixh_core_rstn) ovf_q <= '0;
        else                 ovf_q <= (ovf_q & ~{NTILE{i_ovf_clr}}) | fifo_ovf;
    end

    assign bwd.vld = out_vld;
    assign bwd.dat = out_dat;
    assign bwd.tid = out_tid;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_aixh_mxc_upper_hchain.sv
// tb/tb_aixh_mxc_upper_hchain.sv - self-checking bench for aixh_mxc_upper_hchain (NTILE=4, MASK=4'b1010, DEPTH=4)
module tb_aixh_mxc_upper_hchain;

    localparam int NT  = 4;
    localparam int CW  = 16;
    localparam int DW  = 16;
    localparam int DEP = 4;
    localparam int TW  = 2;
    localparam logic [NT-1:0] MASK = 4'b1010;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              fwd_vld;
    logic [CW-1:0]     fwd_cmd;
    logic [NT-1:0]     tile_cmd_vld;
    logic [NT*CW-1:0]  tile_cmd;
    logic [NT-1:0]     bv;
    logic [NT*DW-1:0]  bd;
    logic [NT-1:0]     ovf;
    logic              ovf_clr;

    aixh_mxc_upper_hchain_if #(.DWIDTH(DW), .TIDW(TW)) bwd_if ();

    aixh_mxc_upper_hchain #(
        .NTILE         (NT),
        .CWIDTH        (CW),
        .DWIDTH        (DW),
        .FIFO_DEPTH    (DEP),
        .REPEATER_MASK (MASK)
    ) dut (
        .aixh_core_clk2x (clk),
        .aixh_core_rstn  (rst_n),
        .i_fwd_vld       (fwd_vld),
        .i_fwd_cmd       (fwd_cmd),
        .o_tile_cmd_vld  (tile_cmd_vld),
        .o_tile_cmd      (tile_cmd),
        .i_tile_bwd_vld  (bv),
        .i_tile_bwd_dat  (bd),
        .bwd             (bwd_if),
        .o_ovf           (ovf),
        .i_ovf_clr       (ovf_clr)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed { logic v; logic [CW-1:0] c; } fwd_t;
    fwd_t           hist [$];          // sampled inputs, most recent first
    logic [DW-1:0]  mq [NT][$];        // per-tile queued results
    logic           m_vld;
    logic [DW-1:0]  m_dat;
    int             m_tid;
    int             m_ptr;
    logic [NT-1:0]  m_ovf;

    function automatic int dly(input int x);
        logic [NT-1:0] m;
        int n;
        m = MASK;
        n = 0;
        for (int i = 0; i <= x; i++) if (m[i]) n++;
        return n;
    endfunction

    task automatic compare();
        for (int x = 0; x < NT; x++) begin
            int d;
            logic ev;
            logic found;
            logic [CW-1:0] ec;
            d = dly(x);
            found = 1'b0;
            if (d == 0) begin
                ev = fwd_vld;
                ec = fwd_cmd;
            end else begin
                ev = (hist.size() >= d) ? hist[d-1].v : 1'b0;
                ec = '0;
                for (int j = d - 1; j < hist.size(); j++)
                    if (!found && hist[j].v) begin
                        ec = hist[j].c;
                        found = 1'b1;
                    end
            end
            chk($sformatf("m_tile%0d_vld", x), tile_cmd_vld[x], ev);
            chk($sformatf("m_tile%0d_cmd", x), tile_cmd[x*CW +: CW], ec);
        end
        chk("m_bwd_vld", bwd_if.vld, m_vld);
        if (m_vld) begin
            chk("m_bwd_dat", bwd_if.dat, m_dat);
            chk("m_bwd_tid", bwd_if.tid, m_tid);
        end
        chk("m_ovf", ovf, m_ovf);
    endtask

    always @(posedge clk) begin
        logic          rdy_s;
        logic          clr_s;
        logic [NT-1:0] bv_s;
        logic [NT-1:0] set;
        logic [NT*DW-1:0] bd_s;
        logic          got;
        int            g;
        rdy_s = bwd_if.rdy;
        clr_s = ovf_clr;
        bv_s  = bv;
        bd_s  = bd;
        if (!rst_n) begin
            hist.delete();
            for (int x = 0; x < NT; x++) mq[x].delete();
            m_vld = 1'b0;
            m_dat = '0;
            m_tid = 0;
            m_ptr = 0;
            m_ovf = '0;
        end else begin
            if (!m_vld || rdy_s) begin
                got = 1'b0;
                g   = 0;
`ifdef AIXH_MXC_HCHAIN_ORDERED_EN
                if (mq[m_ptr].size() > 0) begin
                    got = 1'b1;
                    g   = m_ptr;
                end
`else
                for (int i = 0; i < NT; i++)
                    if (!got && mq[(m_ptr + i) % NT].size() > 0) begin
                        got = 1'b1;
                        g   = (m_ptr + i) % NT;
                    end
`endif
                m_vld = got;
                if (got) begin
                    m_dat = mq[g].pop_front();
                    m_tid = g;
                    m_ptr = (g + 1) % NT;
                end
            end
            set = '0;
            for (int x = 0; x < NT; x++)
                if (bv_s[x]) begin
                    if (mq[x].size() < DEP) mq[x].push_back(bd_s[x*DW +: DW]);
                    else                    set[x] = 1'b1;
                end
            m_ovf = (m_ovf & ~{NT{clr_s}}) | set;
            hist.push_front({fwd_vld, fwd_cmd});
        end
        #1;
        compare();
    end

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        rst_n      = 1'b0;
        fwd_vld    = 1'b0;
        fwd_cmd    = '0;
        bv         = '0;
        bd         = '0;
        ovf_clr    = 1'b0;
        bwd_if.rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_bwd_vld", bwd_if.vld, 1'b0);
        chk("rst_ovf", ovf, 4'b0000);
        chk("rst_tile_vld", tile_cmd_vld, 4'b0000);
        rst_n      = 1'b1;
        bwd_if.rdy = 1'b1;

        // forward delays D = {0,1,1,2}
        @(negedge clk);
        fwd_vld = 1'b1;
        fwd_cmd = 16'h00A5;
        #1;
        chk("fwd_c0_vld", tile_cmd_vld, 4'b0001);
        chk("fwd_c0_t0_cmd", tile_cmd[15:0], 16'h00A5);
        @(negedge clk);
        chk("fwd_c1_vld", tile_cmd_vld, 4'b0111);
        chk("fwd_c1_t1_cmd", tile_cmd[31:16], 16'h00A5);
        chk("fwd_c1_t2_cmd", tile_cmd[47:32], 16'h00A5);
        fwd_vld = 1'b0;
        fwd_cmd = 16'h005A;
        @(negedge clk);
        chk("fwd_c2_vld", tile_cmd_vld, 4'b1000);
        chk("fwd_c2_t3_cmd", tile_cmd[63:48], 16'h00A5);
        chk("fwd_c2_t1_hold", tile_cmd[31:16], 16'h00A5);
        @(negedge clk);
        chk("fwd_c3_vld", tile_cmd_vld, 4'b0000);

        // all tiles push once: back-to-back outputs tid 0..3
        bv = 4'b1111;
        bd = {16'h00D3, 16'h00D2, 16'h00D1, 16'h00D0};
        @(negedge clk);
        bv = '0;
        chk("lat_not_yet", bwd_if.vld, 1'b0);
        for (int i = 0; i < NT; i++) begin
            @(negedge clk);
            chk("burst_vld", bwd_if.vld, 1'b1);
            chk("burst_tid", bwd_if.tid, i);
            chk("burst_dat", bwd_if.dat, 16'h00D0 + i);
        end
        @(negedge clk);
        chk("burst_end", bwd_if.vld, 1'b0);

        // overflow: output slot holds E0, tile2 pushes 6 words with rdy=0
        bwd_if.rdy = 1'b0;
        bv = 4'b0001;
        bd = {48'h0, 16'h00E0};
        @(negedge clk);
        bv = '0;
        @(negedge clk);
        chk("stall_vld", bwd_if.vld, 1'b1);
        chk("stall_dat", bwd_if.dat, 16'h00E0);
        for (int i = 0; i < 6; i++) begin
            bv = 4'b0100;
            bd = {16'h0, 16'h00C0 + 16'(i), 32'h0};
            @(negedge clk);
        end
        bv = '0;
        chk("ovf_set", ovf, 4'b0100);
        chk("stall_hold_dat", bwd_if.dat, 16'h00E0);
        chk("stall_hold_tid", bwd_if.tid, 2'd0);
        bv = 4'b0100;
        bd = {16'h0, 16'h00C6, 32'h0};
        ovf_clr = 1'b1;
        @(negedge clk);
        bv = '0;
        chk("ovf_set_beats_clr", ovf, 4'b0100);
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_cleared", ovf, 4'b0000);
        bwd_if.rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_vld", bwd_if.vld, 1'b1);
            chk("drain_tid", bwd_if.tid, 2'd2);
            chk("drain_dat", bwd_if.dat, 16'h00C0 + i);
        end
        @(negedge clk);
        chk("drain_end", bwd_if.vld, 1'b0);

        // random traffic with rdy toggling 1010..
        for (int c = 0; c < 200; c++) begin
            bwd_if.rdy = ~bwd_if.rdy;
            bv = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            bd = {$urandom, $urandom};
            fwd_vld = 1'($urandom_range(0, 1));
            fwd_cmd = 16'($urandom);
            ovf_clr = ($urandom_range(0, 15) == 0);
            @(negedge clk);
        end
        bv = '0;
        fwd_vld = 1'b0;
        ovf_clr = 1'b0;
        bwd_if.rdy = 1'b1;
        repeat (30) @(negedge clk);
        chk("rand_drained", bwd_if.vld, 1'b0);

        // arbitration policy from a fresh pointer
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bv = 4'b0010;
        bd = {32'h0, 16'h00B1, 16'h0};
        @(negedge clk);
        bv = '0;
`ifdef AIXH_MXC_HCHAIN_ORDERED_EN
        repeat (3) begin
            @(negedge clk);
            chk("ord_wait", bwd_if.vld, 1'b0);
        end
        bv = 4'b0001;
        bd = {48'h0, 16'h00B0};
        @(negedge clk);
        bv = '0;
        @(negedge clk);
        chk("ord_first_tid", bwd_if.tid, 2'd0);
        chk("ord_first_dat", bwd_if.dat, 16'h00B0);
        @(negedge clk);
        chk("ord_second_tid", bwd_if.tid, 2'd1);
        chk("ord_second_dat", bwd_if.dat, 16'h00B1);
`else
        @(negedge clk);
        chk("rr_skip_vld", bwd_if.vld, 1'b1);
        chk("rr_skip_tid", bwd_if.tid, 2'd1);
        chk("rr_skip_dat", bwd_if.dat, 16'h00B1);
`endif
        @(negedge clk);

        // reset with queued words and a command inside the hops
        bwd_if.rdy = 1'b0;
        fwd_vld = 1'b1;
        fwd_cmd = 16'h0077;
        bv = 4'b0111;
        bd = {16'h0, 16'h0012, 16'h0011, 16'h0010};
        @(negedge clk);
        fwd_vld = 1'b0;
        fwd_cmd = '0;
        bv = '0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", bwd_if.vld, 1'b0);
        chk("mid_rst_dat", bwd_if.dat, 16'h0000);
        chk("mid_rst_ovf", ovf, 4'b0000);
        chk("mid_rst_tile_vld", tile_cmd_vld, 4'b0000);
        chk("mid_rst_tile_cmd", tile_cmd, 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bwd_if.rdy = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_vld", bwd_if.vld, 1'b0);
            chk("post_rst_tile_vld", tile_cmd_vld, 4'b0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
